cover_event_collector: RTL and testbench

COVER_EVENT_COLLECTOR -- requirements
Module: cover_event_collector

---
 rtl/cover_pkg.sv | 27 ++
 rtl/cover_prio_enc.sv | 18 +
 rtl/cover_event_collector.sv | 78 +++++++
 tb/tb_cover_event_collector.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cover_pkg.sv
// Shared constants and bit-vector helpers for the coverage event collector.
package cover_pkg;

    localparam int COVER_INDEX_W = 32;

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'b0, v[i]};
        end
        return n;
    endfunction

    // Scanning from the top down leaves the lowest set position as the result.
    function automatic logic [5:0] lowest_set(input logic [63:0] v);
        logic [5:0] p;
        p = '0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) begin
                p = 6'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/cover_prio_enc.sv
// Lowest-set-bit encoder; idx is 0 when no bit is set.
module cover_prio_enc
    import cover_pkg::*;
#(
    parameter int WIDTH = 13,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = IDX_W'(lowest_set(64'(vec)));
        any = |vec;
    end

endmodule

// File: rtl/cover_event_collector.sv
// Records the first hit of each cover point and drains those hits as indexed events.
// Optional synchronous clear port is built when COVER_CLEAR_EN is defined.
module cover_event_collector
    import cover_pkg::*;
#(
    parameter int WIDTH       = 13,
    parameter int COVER_INDEX = 0,
    parameter int INDEX_W     = COVER_INDEX_W
) (
    input  logic                         clock,
    input  logic                         reset,
`ifdef COVER_CLEAR_EN
    input  logic                         clear,
`endif
    input  logic [WIDTH-1:0]             valid,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INDEX_W-1:0]           out_index,
    output logic [$clog2(WIDTH+1)-1:0]   hit_count,
    output logic                         all_covered
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] covered;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] newly;
    logic [WIDTH-1:0] pop_mask;
    logic [IW-1:0]    low_idx;
    logic             any_pending;

    cover_prio_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IW)
    ) u_prio_enc (
        .vec (pending),
        .idx (low_idx),
        .any (any_pending)
    );

    // The presented event is always the lowest pending bit, so isolating it
    // directly gives the pop mask without decoding the index back.
    always_comb begin
        newly    = valid & ~covered;
        pop_mask = '0;
        if (any_pending && out_ready) begin
            pop_mask = pending & (~pending + WIDTH'(1));
        end
    end

    always_comb begin
        out_valid   = any_pending;
        out_index   = INDEX_W'(COVER_INDEX) + INDEX_W'(low_idx);
        all_covered = (hit_count == CW'(WIDTH));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            covered   <= '0;
            pending   <= '0;
            hit_count <= '0;
        end
`ifdef COVER_CLEAR_EN
        else if (clear) begin
            covered   <= '0;
            pending   <= '0;
            hit_count <= '0;
        end
`endif
        else begin
            covered   <= covered | newly;
            pending   <= (pending & ~pop_mask) | newly;
            hit_count <= hit_count + CW'(popcount(64'(newly)));
        end
    end

endmodule

// File: tb/tb_cover_event_collector.sv
// Randomized and directed bench for cover_event_collector against a queue-based model.
module tb_cover_event_collector;

    localparam int W  = 13;
    localparam int CI = 100;
    localparam int CW = $clog2(W + 1);

    logic          clock;
    logic          reset;
    logic [W-1:0]  valid;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_index;
    logic [CW-1:0] hit_count;
    logic          all_covered;
`ifdef COVER_CLEAR_EN
    logic          clear;
`endif

    int vectors;
    int miscompares;
    int ev_count;

    // Model: set of covered points, ascending queue of pending indices.
    bit cov_m[W];
    int pend_q[$];
    int hits_m;

    cover_event_collector #(
        .WIDTH       (W),
        .COVER_INDEX (CI),
        .INDEX_W     (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
`ifdef COVER_CLEAR_EN
        .clear       (clear),
`endif
        .valid       (valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .hit_count   (hit_count),
        .all_covered (all_covered)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        foreach (cov_m[i]) cov_m[i] = 1'b0;
        pend_q.delete();
        hits_m = 0;
    endtask

    task automatic checkAll();
        checkOutput("out_valid", 64'(out_valid), 64'(pend_q.size() > 0));
        if (pend_q.size() > 0) begin
            checkOutput("out_index", 64'(out_index), 64'(CI + pend_q[0]));
        end
        checkOutput("hit_count", 64'(hit_count), 64'(hits_m));
        checkOutput("all_covered", 64'(all_covered), 64'(hits_m == W));
    endtask

    // Called at a falling edge: checks, drives, advances the model, waits one cycle.
    task automatic applyStimulus(input logic [W-1:0] v, input logic rdy);
        int pos;
        bit cleared;
        checkAll();
        if (out_valid && rdy) ev_count++;
        valid     = v;
        out_ready = rdy;
        cleared   = 1'b0;
`ifdef COVER_CLEAR_EN
        if (clear) begin
            modelReset();
            cleared = 1'b1;
        end
`endif
        if (!cleared) begin
            if (rdy && pend_q.size() > 0) void'(pend_q.pop_front());
            for (int i = 0; i < W; i++) begin
                if (v[i] && !cov_m[i]) begin
                    cov_m[i] = 1'b1;
                    hits_m++;
                    pos = 0;
                    while (pos < pend_q.size() && pend_q[pos] < i) pos++;
                    pend_q.insert(pos, i);
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must drop before the next edge.
    task automatic pulseReset();
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_hit_count", 64'(hit_count), 64'd0);
        checkOutput("rst_out_index", 64'(out_index), 64'(CI));
        modelReset();
        ev_count = 0;
        @(negedge clock);
        valid = '0;
        reset = 1'b1;
    endtask

    initial begin
        clock       = 1'b0;
        reset       = 1'b0;
        valid       = '1;
        out_ready   = 1'b0;
        vectors     = 0;
        miscompares = 0;
        ev_count    = 0;
`ifdef COVER_CLEAR_EN
        clear       = 1'b0;
`endif
        modelReset();

        repeat (3) @(negedge clock);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_hit_count", 64'(hit_count), 64'd0);
        checkOutput("rst_all_covered", 64'(all_covered), 64'd0);
        checkOutput("rst_out_index", 64'(out_index), 64'(CI));
        valid = '0;
        reset = 1'b1;

        $display("[TB] single hit on point 0");
        applyStimulus(13'h0001, 1'b1);
        applyStimulus(13'h0000, 1'b1);
        applyStimulus(13'h0000, 1'b1);
        checkOutput("single_hit_events", 64'(ev_count), 64'd1);

        $display("[TB] three hits in one cycle");
        pulseReset();
        applyStimulus(13'h1005, 1'b1);
        repeat (4) applyStimulus(13'h0000, 1'b1);
        checkOutput("multi_hit_events", 64'(ev_count), 64'd3);

        $display("[TB] point 3 held for ten cycles");
        pulseReset();
        repeat (10) applyStimulus(13'h0008, 1'b1);
        applyStimulus(13'h0000, 1'b1);
        checkOutput("held_hit_events", 64'(ev_count), 64'd1);

        $display("[TB] stalled consumer with points 5 and 9");
        pulseReset();
        applyStimulus(13'h0220, 1'b0);
        repeat (4) applyStimulus(13'h0000, 1'b0);
        applyStimulus(13'h0004, 1'b0);
        repeat (2) applyStimulus(13'h0000, 1'b0);
        repeat (4) applyStimulus(13'h0000, 1'b1);
        checkOutput("stall_events", 64'(ev_count), 64'd3);

        $display("[TB] cover every point, then reset mid-drain");
        pulseReset();
        for (int i = 0; i < W; i++) begin
            applyStimulus(W'(1 << i), (i % 3) == 0);
        end
        applyStimulus(13'h0000, 1'b0);
        checkOutput("full_all_covered", 64'(all_covered), 64'd1);
        checkOutput("full_hit_count", 64'(hit_count), 64'(W));
        applyStimulus(13'h0000, 1'b1);
        pulseReset();
        applyStimulus(13'h0000, 1'b1);

`ifdef COVER_CLEAR_EN
        $display("[TB] clear with concurrent hit");
        applyStimulus(13'h0003, 1'b0);
        clear = 1'b1;
        applyStimulus(13'h0002, 1'b1);
        clear = 1'b0;
        applyStimulus(13'h0000, 1'b0);
        checkOutput("clear_hit_count", 64'(hit_count), 64'd0);
        applyStimulus(13'h0002, 1'b0);
        applyStimulus(13'h0000, 1'b1);
        pulseReset();
`endif

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 99) pulseReset();
`ifdef COVER_CLEAR_EN
            clear = ($urandom_range(0, 49) == 0);
`endif
            applyStimulus(W'($urandom & $urandom & $urandom), $urandom_range(0, 3) != 0);
        end
`ifdef COVER_CLEAR_EN
        clear = 1'b0;
`endif
        checkAll();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
